// File: rtl/toggle_pulse_gen.sv
// Push-button conditioner: 2-flop synchronizer, counter debounce FSM and optional
// auto-repeat, producing a single-cycle toggle request for a T flip-flop.
module toggle_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 0,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic en,
    output logic t_pulse,
    output logic btn_level,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic             REPEAT_EN = (REPEAT_CYCLES != 0);
    localparam int               R_LAST_I  = (REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1;
    localparam logic [CNT_W-1:0] D_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] R_LAST    = CNT_W'(R_LAST_I);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] dcnt_reg, dcnt_next;
    logic [CNT_W-1:0] rcnt_reg, rcnt_next;
    logic             s1_reg, s2_reg;
    logic             t_pulse_reg, t_pulse_next;
    logic             btn_level_reg, busy_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
        end else begin
            s1_reg <= btn_in;
            s2_reg <= s1_reg;
        end
    end

    always_comb begin
        state_next   = state_reg;
        dcnt_next    = dcnt_reg;
        rcnt_next    = rcnt_reg;
        t_pulse_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (s2_reg) begin
                    state_next = PRESS_WAIT;
                    dcnt_next  = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s2_reg) begin
                    state_next = IDLE;
                end else if (dcnt_reg == D_LAST) begin
                    state_next   = HELD;
                    rcnt_next    = '0;
                    t_pulse_next = en;
                end else begin
                    dcnt_next = dcnt_reg + 1'b1;
                end
            end
            HELD: begin
                if (!s2_reg) begin
                    state_next = RELEASE_WAIT;
                    dcnt_next  = '0;
                end else if (REPEAT_EN && (rcnt_reg == R_LAST)) begin
                    t_pulse_next = en;
                    rcnt_next    = '0;
                end else if (rcnt_reg != '1) begin
                    // Saturates only matter when repeat is off and the button is held forever.
                    rcnt_next = rcnt_reg + 1'b1;
                end
            end
            RELEASE_WAIT: begin
                if (s2_reg) begin
                    state_next = HELD;
                    rcnt_next  = '0;
                end else if (dcnt_reg == D_LAST) begin
                    state_next = IDLE;
                end else begin
                    dcnt_next = dcnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Level and busy are decoded from the next state so they line up with state_reg.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            dcnt_reg      <= '0;
            rcnt_reg      <= '0;
            t_pulse_reg   <= 1'b0;
            btn_level_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            dcnt_reg      <= dcnt_next;
            rcnt_reg      <= rcnt_next;
            t_pulse_reg   <= t_pulse_next;
            btn_level_reg <= (state_next == HELD) || (state_next == RELEASE_WAIT);
            busy_reg      <= (state_next == PRESS_WAIT) || (state_next == RELEASE_WAIT);
        end
    end

    assign t_pulse   = t_pulse_reg;
    assign btn_level = btn_level_reg;
    assign busy      = busy_reg;

endmodule
